mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter for the single data/instruction memory port. IFU issues reads only; LSU issues reads and writes.
//  It sits between those two units and the memory/AXI bridge, and holds one outstanding transaction at a time.
//  It owns all request/response steering, so each unit sees a private port.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width (wstrb width = DATA_W/8)
//  RR_EN        0  0: fixed priority, LSU wins ties; 1: round-robin between IFU and LSU
// PORTS
//  clock             in   1       system clock
//  reset             in   1       synchronous, active-high
//  ifu_req_valid_i   in   1       IFU read request valid
//  ifu_addr_i        in   ADDR_W  IFU fetch address
//  ifu_req_ready_o   out  1       IFU request accepted
//  ifu_rdata_o       out  DATA_W  read data to IFU
//  ifu_rresp_o       out  2       read response to IFU (00 OKAY, 10 SLVERR, 11 DECERR)
//  ifu_rvalid_o      out  1       read response valid to IFU
//  ifu_rready_i      in   1       IFU accepts read response
//  lsu_req_valid_i   in   1       LSU request valid
//  lsu_we_i          in   1       1 = write, 0 = read
//  lsu_addr_i        in   ADDR_W  LSU address
//  lsu_wdata_i       in   DATA_W  write data
//  lsu_wstrb_i       in   DATA_W/8 write byte strobes
//  lsu_req_ready_o   out  1       LSU request accepted
//  lsu_rdata_o       out  DATA_W  read data to LSU
//  lsu_rresp_o       out  2       read response to LSU
//  lsu_rvalid_o      out  1       read response valid to LSU
//  lsu_rready_i      in   1       LSU accepts read response
//  lsu_bresp_o       out  2       write response to LSU
//  lsu_bvalid_o      out  1       write response valid to LSU
//  lsu_bready_i      in   1       LSU accepts write response
//  mem_req_valid_o / mem_req_ready_i   out/in  1    request handshake to slave
//  mem_we_o / mem_addr_o               out     1/ADDR_W  request kind and address
//  mem_wdata_o / mem_wstrb_o           out     DATA_W/DATA_W/8  write payload
//  mem_rdata_i / mem_rresp_i / mem_rvalid_i  in  DATA_W/2/1  slave read response
//  mem_rready_o                        out     1    read response accept
//  mem_bresp_i / mem_bvalid_i          in      2/1  slave write response
//  mem_bready_o                        out     1    write response accept
// BEHAVIOUR
//  - FSM states: IDLE, REQ, RESP. Registered owner bit (0 = IFU, 1 = LSU), registered owner_we, and last_grant bit.
//  - Reset: state IDLE, owner 0, last_grant 0 (IFU). All valid/ready outputs are 0 while reset is high and in the cycle after it.
//  - IDLE: if any req_valid is high, choose the winner and go to REQ on the next edge. No output is driven in the decision cycle.
//    - Winner with RR_EN=0: LSU if lsu_req_valid_i, else IFU.
//    - Winner with RR_EN=1 and both valid: the master that is not last_grant. last_grant updates on each grant.
//  - REQ: mem_req_valid_o = owner's req_valid. mem_we/addr/wdata/wstrb are muxed from the owner; IFU forces we=0, wstrb=0.
//    - The owner's req_ready_o = mem_req_ready_i. The non-owner's req_ready_o = 0.
//    - On handshake, latch owner_we and go to RESP.
//    - If the owner drops valid before the handshake (protocol violation), return to IDLE.
//  - RESP, read: route mem_rvalid_i/rdata/rresp to the owner. mem_rready_o = owner's rready.
//    - On rvalid & rready, go to IDLE.
//  - RESP, write: route mem_bvalid_i/bresp to lsu_b*. mem_bready_o = lsu_bready_i.
//    - On bvalid & bready, go to IDLE.
//  - mem_rready_o/mem_bready_o are 0 outside RESP; the slave holds its response until accepted.
//  - Response valids to the non-owner are always 0. Data outputs may carry the mux value; they are don't-care when valid is 0.
//  - Minimum turnaround: request valid -> req_ready at cycle +1.
//    - Response can be accepted in the cycle after the request handshake.
//    - Back-to-back grants need one IDLE cycle between transactions.
//  - Grant is held through backpressure: owner rready low keeps state RESP indefinitely, and the other master stalls.
//  - Error responses (SLVERR/DECERR) pass through unchanged. The arbiter does not retry and raises no exception.
//  - Reset in any state returns to IDLE on the next edge. Any in-flight transaction is abandoned; the slave is reset on the same signal.
// STRUCTURE
//  - State encodings and the RESP_* codes belong in the shared riscv_param.vh header.
//  - Single module, no sub-modules. Owner muxes are inline assigns.
//  - Optional `CONFIG_TRACE_PERFORMANCE` DPI counters for grant counts and stall cycles per master.
// TESTING
//  1. Reset held 3 cycles with both masters requesting -> every valid/ready output is 0; first grant appears 1 cycle after reset drops.
//  2. IFU alone reads 0x8000_0000; slave returns 0xDEADBEEF/OKAY after 2 cycles -> ifu_rvalid_o=1, ifu_rdata_o=0xDEADBEEF, lsu_rvalid_o=0.
//  3. Both request in the same cycle:
//     - RR_EN=0 -> LSU read at 0x8000_0100 served first, then IFU.
//     - RR_EN=1 with last_grant=LSU -> IFU is served first.
//  4. LSU write, addr 0xA000_03F8, wdata 0x12345678, wstrb 4'b0011; slave bresp=2'b10 -> mem_we_o=1 and mem_wstrb_o=4'b0011 during REQ; lsu_bresp_o=2'b10, lsu_bvalid_o=1.
//  5. IFU owns RESP with ifu_rready_i low for 3 cycles while LSU requests -> state stays RESP, lsu_req_ready_o=0 throughout; LSU is granted after IFU accepts.
//  6. Reset asserted during RESP with mem_rvalid_i=1 -> next cycle state IDLE, mem_rready_o=0, ifu_rvalid_o=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IFU/LSU memory port arbiter.
// State encoding, response codes and the grant decision.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Round-robin only matters on a tie; otherwise the sole requester wins.
    function automatic logic pick_winner(
        input logic rr_en,
        input logic ifu_v,
        input logic lsu_v,
        input logic last
    );
        if (rr_en && ifu_v && lsu_v) return ~last;
        return lsu_v;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory port arbiter.
// One outstanding transaction; grant held until the response is accepted.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_req_ready_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    output logic [1:0]          ifu_rresp_o,
    output logic                ifu_rvalid_o,
    input  logic                ifu_rready_i,
    input  logic                lsu_req_valid_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    output logic                lsu_req_ready_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic [1:0]          lsu_rresp_o,
    output logic                lsu_rvalid_o,
    input  logic                lsu_rready_i,
    output logic [1:0]          lsu_bresp_o,
    output logic                lsu_bvalid_o,
    input  logic                lsu_bready_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic [1:0]          mem_rresp_i,
    input  logic                mem_rvalid_i,
    output logic                mem_rready_o,
    input  logic [1:0]          mem_bresp_i,
    input  logic                mem_bvalid_i,
    output logic                mem_bready_o
);

    state_t state, next_state;
    logic   owner, owner_we, last_grant;
    logic   any_req, winner, own_valid, own_rready;

    assign any_req    = ifu_req_valid_i | lsu_req_valid_i;
    assign winner     = pick_winner(RR_EN, ifu_req_valid_i,
                                    lsu_req_valid_i, last_grant);
    assign own_valid  = owner ? lsu_req_valid_i : ifu_req_valid_i;
    assign own_rready = owner ? lsu_rready_i : ifu_rready_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_IFU;
            owner_we   <= 1'b0;
            last_grant <= OWN_IFU;
        end else begin
            state <= next_state;
            if (state == S_IDLE && any_req) begin
                owner      <= winner;
                last_grant <= winner;
            end
            if (state == S_REQ && own_valid && mem_req_ready_i)
                owner_we <= owner & lsu_we_i;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (any_req) next_state = S_REQ;
            S_REQ: begin
                if (!own_valid)           next_state = S_IDLE;
                else if (mem_req_ready_i) next_state = S_RESP;
            end
            S_RESP: begin
                if (owner_we) begin
                    if (mem_bvalid_i && lsu_bready_i) next_state = S_IDLE;
                end else if (mem_rvalid_i && own_rready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    logic in_req, rd_phase, wr_phase;

    // Gating with reset keeps every handshake quiet during the reset cycle.
    always_comb begin
        in_req   = (state == S_REQ) && !reset;
        rd_phase = (state == S_RESP) && !reset && !owner_we;
        wr_phase = (state == S_RESP) && !reset && owner_we;

        mem_req_valid_o = in_req & own_valid;
        mem_we_o        = owner & lsu_we_i;
        mem_addr_o      = owner ? lsu_addr_i : ifu_addr_i;
        mem_wdata_o     = lsu_wdata_i;
        mem_wstrb_o     = owner ? lsu_wstrb_i : '0;
        ifu_req_ready_o = in_req & ~owner & mem_req_ready_i;
        lsu_req_ready_o = in_req & owner & mem_req_ready_i;

        ifu_rvalid_o = rd_phase & ~owner & mem_rvalid_i;
        lsu_rvalid_o = rd_phase & owner & mem_rvalid_i;
        mem_rready_o = rd_phase & own_rready;
        ifu_rdata_o  = mem_rdata_i;
        lsu_rdata_o  = mem_rdata_i;
        ifu_rresp_o  = mem_rresp_i;
        lsu_rresp_o  = mem_rresp_i;

        lsu_bvalid_o = wr_phase & mem_bvalid_i;
        lsu_bresp_o  = mem_bresp_i;
        mem_bready_o = wr_phase & lsu_bready_i;
    end

endmodule
